// File: rtl/fft8_stream_pipe.sv
// ============================================================================
// Module      : fft8_stream_pipe
// Description : 8-point radix-2 DIT FFT/IFFT with valid/ready streaming I/O.
//               Buffers a frame of 8 samples in bit-reversed order, runs three
//               in-place butterfly stages (one per cycle), then streams the
//               8 bins out in natural order. Per-stage scaling, saturation with
//               a sticky overflow flag, and conjugate-twiddle inverse mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft8_stream_pipe #(
  parameter int DATA_W  = 16,
  parameter int TW_FRAC = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic                     inverse,
  input  logic                     scale_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [2:0]               out_index,
  output logic                     out_last,
  output logic                     ovf
);

  // Butterfly working width: a (DATA_W) plus a twiddled term (DATA_W+1) needs one more bit.
  localparam int SW = DATA_W + 2;
  localparam int PW = DATA_W + TW_FRAC + 4;
  localparam int c_TW = $rtoi(0.7071 * (2.0 ** TW_FRAC) + 0.5);

  localparam logic signed [PW-1:0] c_TW_P = PW'(c_TW);
  localparam logic signed [PW-1:0] c_RND  = PW'(2 ** (TW_FRAC - 1));
  localparam logic signed [PW-1:0] c_TMAX = {{(PW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic signed [PW-1:0] c_TMIN = {{(PW-DATA_W){1'b1}}, {DATA_W{1'b0}}};
  localparam logic signed [SW-1:0] c_OMAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] c_OMIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [2:0] c_ST_LOAD   = 3'd0;
  localparam logic [2:0] c_ST_S1     = 3'd1;
  localparam logic [2:0] c_ST_S2     = 3'd2;
  localparam logic [2:0] c_ST_S3     = 3'd3;
  localparam logic [2:0] c_ST_UNLOAD = 3'd4;

  logic [2:0]               r_state;
  logic [2:0]               r_cnt;
  logic                     r_inv;
  logic                     r_scale;
  logic                     r_ovf;
  logic signed [DATA_W-1:0] r_re [8];
  logic signed [DATA_W-1:0] r_im [8];
  logic                     r_oval;
  logic signed [DATA_W-1:0] r_ore;
  logic signed [DATA_W-1:0] r_oim;
  logic [2:0]               r_oidx;
  logic                     r_olast;

  logic signed [DATA_W-1:0] w_nre [8];
  logic signed [DATA_W-1:0] w_nim [8];
  logic                     w_sat;

  // C*s with round-half-up, then clamp to DATA_W+1 bits.
  function automatic logic signed [DATA_W:0] f_cmul(input logic signed [SW-1:0] s);
    logic signed [PW-1:0] p;
    p = $signed({{(PW-SW){s[SW-1]}}, s}) * c_TW_P + c_RND;
    p = p >>> TW_FRAC;
    if (p > c_TMAX) p = c_TMAX;
    if (p < c_TMIN) p = c_TMIN;
    return p[DATA_W:0];
  endfunction

  // Twiddle multiply of b by W8^e (conjugated when inverse); returns {real, imag}.
  function automatic logic [2*DATA_W+1:0] f_tw(input logic signed [DATA_W-1:0] br,
                                               input logic signed [DATA_W-1:0] bi,
                                               input logic [1:0] e, input logic inv);
    logic signed [SW-1:0] xr, xi, s_add, s_dif, s_neg, n_r, n_i;
    logic signed [DATA_W:0] tr, ti;
    xr    = SW'(br);
    xi    = SW'(bi);
    s_add = xr + xi;
    s_dif = xi - xr;
    s_neg = -xr - xi;
    n_r   = -xr;
    n_i   = -xi;
    case (e)
      2'd0: begin tr = xr[DATA_W:0]; ti = xi[DATA_W:0]; end
      2'd1: begin
        tr = inv ? f_cmul(-s_dif) : f_cmul(s_add);
        ti = inv ? f_cmul(s_add)  : f_cmul(s_dif);
      end
      2'd2: begin
        tr = inv ? n_i[DATA_W:0] : xi[DATA_W:0];
        ti = inv ? xr[DATA_W:0]  : n_r[DATA_W:0];
      end
      default: begin
        tr = inv ? f_cmul(s_neg)  : f_cmul(s_dif);
        ti = inv ? f_cmul(-s_dif) : f_cmul(s_neg);
      end
    endcase
    return {tr, ti};
  endfunction

  // Optional floor halving, then clamp to DATA_W; returns {saturated, value}.
  function automatic logic [DATA_W:0] f_fin(input logic signed [SW-1:0] v, input logic sc);
    logic signed [SW-1:0] t;
    logic                 f;
    t = sc ? (v >>> 1) : v;
    f = 1'b0;
    if (t > c_OMAX) begin t = c_OMAX; f = 1'b1; end
    if (t < c_OMIN) begin t = c_OMIN; f = 1'b1; end
    return {f, t[DATA_W-1:0]};
  endfunction

  // One butterfly stage over the whole buffer; span and twiddles chosen by state.
  always_comb begin
    logic [2:0]              w_top, w_bot;
    logic [1:0]              w_e;
    logic [2*DATA_W+1:0]     w_tw;
    logic signed [SW-1:0]    w_ar, w_ai, w_tr, w_ti;
    logic [DATA_W:0]         w_r0, w_i0, w_r1, w_i1;
    w_nre = r_re;
    w_nim = r_im;
    w_sat = 1'b0;
    for (int b = 0; b < 4; b++) begin
      case (r_state)
        c_ST_S1: begin w_top = 3'(2*b); w_bot = 3'(2*b + 1); w_e = 2'd0; end
        c_ST_S2: begin w_top = 3'(4*(b/2) + (b%2)); w_bot = 3'(4*(b/2) + (b%2) + 2); w_e = 2'((b%2)*2); end
        default: begin w_top = 3'(b); w_bot = 3'(b + 4); w_e = 2'(b); end
      endcase
      w_tw = f_tw(r_re[w_bot], r_im[w_bot], w_e, r_inv);
      w_ar = SW'(r_re[w_top]);
      w_ai = SW'(r_im[w_top]);
      w_tr = SW'($signed(w_tw[2*DATA_W+1:DATA_W+1]));
      w_ti = SW'($signed(w_tw[DATA_W:0]));
      w_r0 = f_fin(w_ar + w_tr, r_scale);
      w_i0 = f_fin(w_ai + w_ti, r_scale);
      w_r1 = f_fin(w_ar - w_tr, r_scale);
      w_i1 = f_fin(w_ai - w_ti, r_scale);
      w_nre[w_top] = w_r0[DATA_W-1:0];
      w_nim[w_top] = w_i0[DATA_W-1:0];
      w_nre[w_bot] = w_r1[DATA_W-1:0];
      w_nim[w_bot] = w_i1[DATA_W-1:0];
      w_sat = w_sat | w_r0[DATA_W] | w_i0[DATA_W] | w_r1[DATA_W] | w_i1[DATA_W];
    end
  end

  // Frame sequencer: load, three compute stages, unload with backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_LOAD;
      r_cnt   <= 3'd0;
      r_inv   <= 1'b0;
      r_scale <= 1'b0;
      r_ovf   <= 1'b0;
      r_oval  <= 1'b0;
      r_ore   <= '0;
      r_oim   <= '0;
      r_oidx  <= 3'd0;
      r_olast <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else begin
      case (r_state)
        c_ST_LOAD: begin
          if (in_valid) begin
            r_re[{r_cnt[0], r_cnt[1], r_cnt[2]}] <= in_real;
            r_im[{r_cnt[0], r_cnt[1], r_cnt[2]}] <= in_imag;
            if (r_cnt == 3'd0) begin
              r_inv   <= inverse;
              r_scale <= scale_en;
              r_ovf   <= 1'b0;
            end
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= c_ST_S1;
          end
        end
        c_ST_S1, c_ST_S2, c_ST_S3: begin
          r_re <= w_nre;
          r_im <= w_nim;
          if (w_sat) r_ovf <= 1'b1;
          if (r_state == c_ST_S3) begin
            // Bin 0 comes straight from the final stage so it is valid on the same edge.
            r_state <= c_ST_UNLOAD;
            r_oval  <= 1'b1;
            r_ore   <= w_nre[0];
            r_oim   <= w_nim[0];
            r_oidx  <= 3'd0;
            r_olast <= 1'b0;
          end else begin
            r_state <= r_state + 3'd1;
          end
        end
        c_ST_UNLOAD: begin
          if (out_ready) begin
            if (r_oidx == 3'd7) begin
              r_oval  <= 1'b0;
              r_olast <= 1'b0;
              r_cnt   <= 3'd0;
              r_state <= c_ST_LOAD;
            end else begin
              r_oidx  <= r_oidx + 3'd1;
              r_ore   <= r_re[r_oidx + 3'd1];
              r_oim   <= r_im[r_oidx + 3'd1];
              r_olast <= (r_oidx == 3'd6);
            end
          end
        end
        default: r_state <= c_ST_LOAD;
      endcase
    end
  end

  assign in_ready  = rst_n & (r_state == c_ST_LOAD);
  assign out_valid = r_oval;
  assign out_real  = r_ore;
  assign out_imag  = r_oim;
  assign out_index = r_oidx;
  assign out_last  = r_olast;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire
